// File: rtl/rgb_to_ycbcr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_to_ycbcr_pkg
//  Description : Shared constants and types for the RGB -> full-range BT.601
//                YCbCr converter: Q14 coefficients, accumulator width, offset,
//                pipeline latency, sync bundle type and the output clamp.
//  Ports       : (package, none)
//  Revision    : 1.0 - initial release
// ============================================================================
package rgb_to_ycbcr_pkg;

  localparam int FRAC_BITS = 14;
  localparam int ACC_W     = 26;
  localparam int PIPE_LAT  = 3;

  localparam logic signed [ACC_W-1:0] OFFSET_128 = 26'sd2097152;  // 128 << 14
  localparam logic signed [ACC_W-1:0] OFFSET_0   = 26'sd0;

  // Q14 coefficients, one row per output component.
  localparam logic signed [15:0] YR  =  16'sd4899;
  localparam logic signed [15:0] YG  =  16'sd9617;
  localparam logic signed [15:0] YB  =  16'sd1868;
  localparam logic signed [15:0] CBR = -16'sd2765;
  localparam logic signed [15:0] CBG = -16'sd5427;
  localparam logic signed [15:0] CBB =  16'sd8192;
  localparam logic signed [15:0] CRR =  16'sd8192;
  localparam logic signed [15:0] CRG = -16'sd6860;
  localparam logic signed [15:0] CRB = -16'sd1332;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } sync_t;

  // Clamp an already-shifted signed value into 0..255.
  function automatic logic [7:0] sat_u8(input logic signed [ACC_W-1:0] v);
    logic [7:0] r;
    if (v[ACC_W-1]) begin
      r = 8'd0;
    end else if (|v[ACC_W-2:8]) begin
      r = 8'd255;
    end else begin
      r = v[7:0];
    end
    return r;
  endfunction

endpackage : rgb_to_ycbcr_pkg
`default_nettype wire

// File: rtl/rgb_to_ycbcr_channel.sv
`default_nettype none
// ============================================================================
//  Module      : ycbcr_channel
//  Description : One output component: three Q14 products, sum with offset,
//                arithmetic shift and clamp. Three ce-gated register stages.
//  Ports       : clk, rst_n (async, active-low), ce,
//                a/b/c [7:0] unsigned inputs (R, G, B),
//                comp [7:0] registered component output
//  Revision    : 1.0 - initial release
// ============================================================================
module ycbcr_channel
  import rgb_to_ycbcr_pkg::*;
#(
  parameter logic signed [15:0]      COEF_A = 16'sd0,
  parameter logic signed [15:0]      COEF_B = 16'sd0,
  parameter logic signed [15:0]      COEF_C = 16'sd0,
  parameter logic signed [ACC_W-1:0] OFFSET = 26'sd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] c,
  output logic [7:0] comp
);

  localparam logic signed [ACC_W-1:0] K_A = COEF_A;
  localparam logic signed [ACC_W-1:0] K_B = COEF_B;
  localparam logic signed [ACC_W-1:0] K_C = COEF_C;

  logic signed [ACC_W-1:0] pa_d, pb_d, pc_d, pa_q, pb_q, pc_q;
  logic signed [ACC_W-1:0] sum_d, sum_q;
  logic signed [ACC_W-1:0] shifted;
  logic [7:0]              comp_d, comp_q;
  // Stage-valid flags keep the output at 0 until a real pixel has reached
  // stage 3; otherwise the offset alone would leak out as 128 after reset.
  logic                    v1_d, v1_q, v2_d, v2_q;

  always_comb begin
    pa_d    = pa_q;
    pb_d    = pb_q;
    pc_d    = pc_q;
    sum_d   = sum_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    comp_d  = comp_q;
    shifted = sum_q >>> FRAC_BITS;
    if (ce) begin
      pa_d   = K_A * $signed({{(ACC_W-8){1'b0}}, a});
      pb_d   = K_B * $signed({{(ACC_W-8){1'b0}}, b});
      pc_d   = K_C * $signed({{(ACC_W-8){1'b0}}, c});
      sum_d  = pa_q + pb_q + pc_q + OFFSET;
      v1_d   = 1'b1;
      v2_d   = v1_q;
      comp_d = v2_q ? sat_u8(shifted) : 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pa_q   <= '0;
      pb_q   <= '0;
      pc_q   <= '0;
      sum_q  <= '0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      comp_q <= 8'd0;
    end else begin
      pa_q   <= pa_d;
      pb_q   <= pb_d;
      pc_q   <= pc_d;
      sum_q  <= sum_d;
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      comp_q <= comp_d;
    end
  end

  assign comp = comp_q;

endmodule : ycbcr_channel
`default_nettype wire

// File: rtl/rgb_to_ycbcr.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_to_ycbcr
//  Description : Pixel-stream RGB888 -> full-range BT.601 YCbCr converter with
//                sync/de delay line matched to the 3-stage datapath.
//  Ports       : clk, rst_n (async, active-low), ce (pipeline advance),
//                R/G/B [7:0] in, in_hsync/in_vsync/in_de in,
//                Y/Cb/Cr [7:0] out, out_hsync/out_vsync/out_de out
//  Revision    : 1.0 - initial release
// ============================================================================
module rgb_to_ycbcr
  import rgb_to_ycbcr_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce,
  input  logic [7:0] R,
  input  logic [7:0] G,
  input  logic [7:0] B,
  input  logic       in_hsync,
  input  logic       in_vsync,
  input  logic       in_de,
  output logic [7:0] Y,
  output logic [7:0] Cb,
  output logic [7:0] Cr,
  output logic       out_hsync,
  output logic       out_vsync,
  output logic       out_de
);

  ycbcr_channel #(.COEF_A(YR),  .COEF_B(YG),  .COEF_C(YB),  .OFFSET(OFFSET_0)) u_y (
    .clk(clk), .rst_n(rst_n), .ce(ce), .a(R), .b(G), .c(B), .comp(Y)
  );

  ycbcr_channel #(.COEF_A(CBR), .COEF_B(CBG), .COEF_C(CBB), .OFFSET(OFFSET_128)) u_cb (
    .clk(clk), .rst_n(rst_n), .ce(ce), .a(R), .b(G), .c(B), .comp(Cb)
  );

  ycbcr_channel #(.COEF_A(CRR), .COEF_B(CRG), .COEF_C(CRB), .OFFSET(OFFSET_128)) u_cr (
    .clk(clk), .rst_n(rst_n), .ce(ce), .a(R), .b(G), .c(B), .comp(Cr)
  );

  // Sync delay line: same depth and same ce gating as the datapath.
  sync_t sync_d [PIPE_LAT];
  sync_t sync_q [PIPE_LAT];

  always_comb begin
    for (int i = 0; i < PIPE_LAT; i++) begin
      sync_d[i] = sync_q[i];
    end
    if (ce) begin
      sync_d[0] = '{hsync: in_hsync, vsync: in_vsync, de: in_de};
      for (int i = 1; i < PIPE_LAT; i++) begin
        sync_d[i] = sync_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign out_hsync = sync_q[PIPE_LAT-1].hsync;
  assign out_vsync = sync_q[PIPE_LAT-1].vsync;
  assign out_de    = sync_q[PIPE_LAT-1].de;

endmodule : rgb_to_ycbcr
`default_nettype wire

// File: tb/tb_rgb_to_ycbcr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rgb_to_ycbcr
//  Description : Scoreboard bench for rgb_to_ycbcr. Stimulus pushes the
//                hand-computed expected output for every enabled pixel; a
//                monitor pops and compares as pixels emerge, checks that
//                outputs hold while ce=0 and stay 0 until the first pixel.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb_to_ycbcr;

  logic       clk = 1'b0;
  logic       rst_n, ce;
  logic [7:0] R, G, B;
  logic       in_hsync, in_vsync, in_de;
  logic [7:0] Y, Cb, Cr;
  logic       out_hsync, out_vsync, out_de;

  rgb_to_ycbcr dut (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .R(R), .G(G), .B(B),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de),
    .Y(Y), .Cb(Cb), .Cr(Cr),
    .out_hsync(out_hsync), .out_vsync(out_vsync), .out_de(out_de)
  );

  always #5 clk = ~clk;

  // Directed vectors with hand-computed full-range BT.601 results (floor).
  logic [7:0] t_r  [8] = '{243,   0, 255, 255,   0,   0, 100,  10};
  logic [7:0] t_g  [8] = '{ 12,   0, 255,   0,   0, 255, 150,  20};
  logic [7:0] t_b  [8] = '{ 45,   0, 255,   0, 255,   0, 200,  30};
  logic [7:0] t_y  [8] = '{ 84,   0, 255,  76,  29, 149, 140,  18};
  logic [7:0] t_cb [8] = '{105, 128, 128,  84, 255,  43, 161, 134};
  logic [7:0] t_cr [8] = '{240, 128, 128, 255, 107,  21,  98, 122};

  logic [26:0] sbq[$];   // {Y, Cb, Cr, hsync, vsync, de}
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [26:0] act, input logic [26:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got Y=%0d Cb=%0d Cr=%0d h/v/de=%b, want Y=%0d Cb=%0d Cr=%0d h/v/de=%b",
               name, act[26:19], act[18:11], act[10:3], act[2:0],
               exp[26:19], exp[18:11], exp[10:3], exp[2:0]);
    end
  endtask

  function automatic logic [26:0] outs();
    return {Y, Cb, Cr, out_hsync, out_vsync, out_de};
  endfunction

  // Drive one cycle; record the expected result if the pipeline will take it.
  task automatic drive(input int idx, input logic h, input logic v, input logic d, input logic en);
    @(negedge clk);
    R = t_r[idx]; G = t_g[idx]; B = t_b[idx];
    in_hsync = h; in_vsync = v; in_de = d; ce = en;
    if (en && rst_n) sbq.push_back({t_y[idx], t_cb[idx], t_cr[idx], h, v, d});
  endtask

  // Monitor
  initial begin
    int          en_cnt;
    logic        en;
    logic [26:0] last;
    logic [26:0] exp;
    en_cnt = 0;
    last   = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        en_cnt = 0;
        sbq.delete();
      end else begin
        en = ce;
        #1;
        if (en) begin
          en_cnt++;
          if (en_cnt >= 3) begin
            if (sbq.size() == 0) begin
              n_checks++;
              n_errors++;
              $display("FAIL pix: output appeared with empty scoreboard, got %h", outs());
            end else begin
              exp = sbq.pop_front();
              chk("pix", outs(), exp);
            end
          end else begin
            chk("pre_valid_zero", outs(), 27'd0);
          end
          last = outs();
        end else if (en_cnt >= 3) begin
          chk("ce_hold", outs(), last);
        end
      end
    end
  end

  // Stimulus
  initial begin
    rst_n = 1'b0; ce = 1'b0;
    R = 8'd0; G = 8'd0; B = 8'd0;
    in_hsync = 1'b0; in_vsync = 1'b0; in_de = 1'b0;

    repeat (2) @(posedge clk);
    #1 chk("reset_state", outs(), 27'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // All directed colours, simple sync pattern.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] k;
      k = 3'(i);
      drive(i, k[0], k[1], ~k[2], 1'b1);
    end

    // Distinct sync/de pattern each cycle, pixels cycling through the table.
    for (int j = 0; j < 16; j++) begin
      logic [3:0] k;
      k = 4'(j);
      drive(j % 8, k[0], k[1] ^ k[3], ~k[2], 1'b1);
    end

    // Stall: inputs change while ce=0; queued pixels must emerge in order.
    drive(6, 1'b1, 1'b0, 1'b1, 1'b1);
    drive(7, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int s = 0; s < 5; s++) drive(s, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(i + 2, 1'b0, 1'b0, 1'b1, 1'b1);

    // Asynchronous reset between clock edges, mid-stream.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    ce    = 1'b0;
    #1 chk("async_reset", outs(), 27'd0);
    repeat (2) @(posedge clk);
    #1 chk("reset_held", outs(), 27'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) drive(7 - i, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive(1, 1'b0, 1'b0, 1'b0, 1'b1);

    @(negedge clk);
    ce = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_rgb_to_ycbcr
`default_nettype wire
